// File: rtl/spi_rom_reader.sv
// Serial-flash read sequencer driving one SPI master (mode 0, 8-bit, MSB first).
// Define SPI_ROM_FAST_READ_EN to issue FAST READ (0x0B) with one dummy byte.
module spi_rom_reader #(
  parameter int DIV   = 2,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rd_req_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       data_o,
  output logic             data_vld_o,
  output logic             ss_n_o,
  output logic             spi_ena_o,
  output logic             spi_start_o,
  output logic [7:0]       spi_tx_o,
  input  logic [7:0]       spi_rx_i,
  input  logic             spi_irq_i,
  output logic             spi_ack_o
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef SPI_ROM_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_CMD, S_A2, S_A1, S_A0,
`ifdef SPI_ROM_FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA, S_HOLD
  } state_e;

  state_e           state_q, state_d, next_byte;
  logic             send_q, send_d;
  logic [DW-1:0]    div_q, div_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ss_n_q, ss_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       data_q, data_d;
  logic             vld_q, vld_d;

  assign spi_ena_o  = (div_q == DW'(DIV - 1));
  assign ss_n_o     = ss_n_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign data_o     = data_q;
  assign data_vld_o = vld_q;

  always_comb begin
    state_d     = state_q;
    send_d      = send_q;
    div_d       = spi_ena_o ? '0 : div_q + DW'(1);
    addr_d      = addr_q;
    rem_d       = rem_q;
    ss_n_d      = ss_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    data_d      = data_q;
    vld_d       = 1'b0;
    spi_start_o = 1'b0;
    spi_ack_o   = 1'b0;
    spi_tx_o    = 8'h00;
    next_byte   = S_HOLD;

    case (state_q)
      S_IDLE: begin
        if (rd_req_i) begin
          if (len_i != '0) begin
            addr_d  = addr_i;
            rem_d   = len_i;
            ss_n_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = S_SETUP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (abort_i) begin
          state_d = S_HOLD;
        end else if (spi_ena_o) begin
          send_d  = 1'b1;
          state_d = S_CMD;
        end
      end
      S_HOLD: begin
        if (spi_ena_o) begin
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        // Byte states: tx byte and successor are fixed by the current state.
        case (state_q)
          S_CMD: begin spi_tx_o = READ_CMD;      next_byte = S_A2; end
          S_A2:  begin spi_tx_o = addr_q[23:16]; next_byte = S_A1; end
          S_A1:  begin spi_tx_o = addr_q[15:8];  next_byte = S_A0; end
`ifdef SPI_ROM_FAST_READ_EN
          S_A0:    begin spi_tx_o = addr_q[7:0]; next_byte = S_DUMMY; end
          S_DUMMY: begin spi_tx_o = 8'h00;       next_byte = S_DATA;  end
`else
          S_A0:  begin spi_tx_o = addr_q[7:0];   next_byte = S_DATA; end
`endif
          S_DATA: begin
            spi_tx_o  = 8'h00;
            next_byte = (rem_q == LEN_W'(1)) ? S_HOLD : S_DATA;
          end
          default: begin spi_tx_o = 8'h00; next_byte = S_HOLD; end
        endcase

        if (send_q) begin
          spi_start_o = 1'b1;
          send_d      = 1'b0;
          div_d       = '0;
        end else if (spi_irq_i) begin
          spi_ack_o = 1'b1;
          send_d    = 1'b1;
          state_d   = abort_i ? S_HOLD : next_byte;
          if (state_q == S_DATA) begin
            data_d = spi_rx_i;
            vld_d  = 1'b1;
            rem_d  = rem_q - LEN_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      send_q  <= 1'b0;
      div_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
      div_q   <= div_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      ss_n_q  <= ss_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_spi_rom_reader.sv
// Bench for spi_rom_reader: behavioural SPI master + flash, scoreboard of received bytes.
// SPI_ROM_FAST_READ_EN selects the fast-read expectations.
module tb_spi_rom_reader;

`ifdef SPI_ROM_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int         HDR = 5;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int         HDR = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic        abort = 1'b0;
  logic        busy_o, done_o, data_vld_o, ss_n_o, spi_ena_o, spi_start_o, spi_ack_o;
  logic [7:0]  data_o, spi_tx_o;
  logic [7:0]  spi_rx = 8'h00;
  logic        spi_irq = 1'b0;

  logic [7:0]  mem [0:4095];
  logic [7:0]  got_q[$];
  logic [7:0]  mosi_q[$];
  int          done_cnt, ss_low, n_start, ss_bad;
  int          n_chk = 0, n_pass = 0;

  spi_rom_reader #(.DIV(2), .LEN_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rd_req_i(rd_req), .addr_i(addr), .len_i(len),
    .abort_i(abort), .busy_o(busy_o), .done_o(done_o), .data_o(data_o),
    .data_vld_o(data_vld_o), .ss_n_o(ss_n_o), .spi_ena_o(spi_ena_o),
    .spi_start_o(spi_start_o), .spi_tx_o(spi_tx_o), .spi_rx_i(spi_rx),
    .spi_irq_i(spi_irq), .spi_ack_o(spi_ack_o)
  );

  always #5 clk = ~clk;

  // SPI master + flash: a byte takes 16 ena ticks; irq drops one cycle after ack.
  initial begin : master
    int          ticks, idx;
    bit          active, ack_seen;
    logic [23:0] fa;
    logic [7:0]  resp;
    ticks = 0; idx = 0; active = 0; ack_seen = 0; fa = '0; resp = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        active = 0; ack_seen = 0; spi_irq = 1'b0; idx = 0;
      end else begin
        if (ss_n_o) idx = 0;
        if (ack_seen) begin spi_irq = 1'b0; ack_seen = 0; end
        if (spi_start_o) begin
          n_start++;
          if (ss_n_o !== 1'b0) ss_bad++;
          mosi_q.push_back(spi_tx_o);
          if (idx == 1) fa[23:16] = spi_tx_o;
          if (idx == 2) fa[15:8]  = spi_tx_o;
          if (idx == 3) fa[7:0]   = spi_tx_o;
          resp = (idx >= HDR) ? mem[12'(fa + 24'(idx - HDR))] : 8'hEE;
          idx++;
          active = 1; ticks = 0;
        end else if (active && spi_ena_o) begin
          ticks++;
          if (ticks == 16) begin spi_irq = 1'b1; spi_rx = resp; active = 0; end
        end
      end
      @(negedge clk);
      if (spi_irq && spi_ack_o) ack_seen = 1;
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      if (data_vld_o) got_q.push_back(data_o);
      if (done_o) done_cnt++;
      if (!ss_n_o) ss_low++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin n_pass++; end
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic clear_sb();
    got_q.delete(); mosi_q.delete();
    done_cnt = 0; ss_low = 0; n_start = 0; ss_bad = 0;
  endtask

  task automatic do_req(input logic [23:0] a, input int l);
    rd_req = 1'b1; addr = a; len = 16'(l);
    step();
    rd_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin step(); c++; end
    chk({tag, "_timeout"}, (done_cnt != 0), 1);
    repeat (4) step();
  endtask

  // Reference: MOSI is cmd, 3 address bytes, [dummy], then zeros; data is mem[a+i].
  task automatic chk_read(input string tag, input logic [23:0] a, input int len_req, input int n_got);
    logic [7:0] exp_q[$];
    logic [7:0] exp_mosi[$];
    exp_mosi = {CMD, a[23:16], a[15:8], a[7:0]};
    if (HDR == 5) exp_mosi.push_back(8'h00);
    for (int i = 0; i < n_got; i++) exp_mosi.push_back(8'h00);
    for (int i = 0; i < len_req; i++) exp_q.push_back(mem[12'(a + 24'(i))]);
    chk({tag, "_ndata"}, got_q.size(), n_got);
    for (int i = 0; i < n_got && i < got_q.size(); i++) chk({tag, "_data"}, got_q[i], exp_q[i]);
    chk({tag, "_nmosi"}, mosi_q.size(), exp_mosi.size());
    for (int i = 0; i < exp_mosi.size() && i < mosi_q.size(); i++) chk({tag, "_mosi"}, mosi_q[i], exp_mosi[i]);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_ss"}, ss_n_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ss_at_start"}, ss_bad, 0);
  endtask

  initial begin : main
    logic [23:0] ra;
    int          rl, n, lo, c;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[16] = 8'hA5; mem[17] = 8'h5A; mem[18] = 8'h00; mem[19] = 8'hFF;
    clear_sb();

    repeat (3) step();
    chk("rst_ss", ss_n_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_vld", data_vld_o, 0);
    chk("rst_start", spi_start_o, 0);
    chk("rst_ack", spi_ack_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_tx", spi_tx_o, 0);
    chk("rst_ena", spi_ena_o, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // T1: directed read of the known pattern
    clear_sb();
    do_req(24'h000010, 4);
    wait_done("t1", 1000);
    chk_read("t1", 24'h000010, 4, 4);
    lo = (HDR + 4) * 32;
    chk("t1_ss_low_min", (ss_low >= lo), 1);
    chk("t1_ss_low_max", (ss_low <= lo + (HDR + 4) * 8 + 16), 1);

    // T2: zero-length request
    clear_sb();
    do_req(24'h000123, 0);
    chk("t2_done", done_o, 1);
    chk("t2_ss", ss_n_o, 1);
    chk("t2_busy", busy_o, 0);
    step();
    chk("t2_done_1cyc", done_o, 0);
    repeat (20) step();
    chk("t2_nstart", n_start, 0);
    chk("t2_ndone", done_cnt, 1);

    // T3: abort at the third delivered byte
    clear_sb();
    ra = 24'($urandom);
    do_req(ra, 8);
    c = 0;
    while (got_q.size() < 3 && c < 2000) begin step(); c++; end
    chk("t3_third_timeout", (got_q.size() >= 3), 1);
    abort = 1'b1;
    wait_done("t3", 1000);
    abort = 1'b0;
    n = got_q.size();
    chk("t3_count_3or4", (n == 3 || n == 4), 1);
    chk_read("t3", ra, 8, n);

    // T4: asynchronous reset during A1
    clear_sb();
    ra = 24'($urandom);
    do_req(ra, 5);
    c = 0;
    while (n_start < 3 && c < 500) begin step(); c++; end
    chk("t4_a1_timeout", (n_start >= 3), 1);
    repeat (5) step();
    #1 rst_n = 1'b0;
    #1;
    chk("t4_ss_async", ss_n_o, 1);
    chk("t4_busy_async", busy_o, 0);
    chk("t4_start_async", spi_start_o, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    clear_sb();
    ra = 24'($urandom);
    do_req(ra, 4);
    wait_done("t4b", 1000);
    chk_read("t4b", ra, 4, 4);

    // T5: request while busy is ignored
    clear_sb();
    ra = 24'($urandom);
    do_req(ra, 3);
    repeat (20) step();
    chk("t5_busy", busy_o, 1);
    do_req(~ra, 7);
    wait_done("t5", 1000);
    repeat (60) step();
    chk_read("t5", ra, 3, 3);

`ifdef SPI_ROM_FAST_READ_EN
    // T6: fast read directed
    clear_sb();
    do_req(24'h000100, 2);
    wait_done("t6", 1000);
    chk_read("t6", 24'h000100, 2, 2);
`endif

    // Random reads
    for (int k = 0; k < 4; k++) begin
      clear_sb();
      ra = 24'($urandom);
      rl = $urandom_range(1, 5);
      do_req(ra, rl);
      wait_done("rnd", 2000);
      chk_read("rnd", ra, rl, rl);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
